// File: rtl/nanojeff_mem.sv
// nanojeff_mem: memory-side responder for the NanoJeff core.
// Holds the core in reset while a boot image streams in over a
// valid/ready byte interface, then serves instruction fetches and data
// loads/stores from a register array, with one memory-mapped LED bit.
//
// state  | meaning
// -------+---------------------------------------------------------
// S_LOAD | core held in reset; boot bytes written at ptr
// S_RUN  | core running; core writes update memory or the LED bit
module nanojeff_mem #(
  parameter int                 ADDR_W   = 8,
  parameter int                 BOOT_LEN = 256,
  parameter logic [ADDR_W-1:0]  LED_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [7:0]        inst,
  input  logic [ADDR_W-1:0] daddr,
  output logic [7:0]        data,
  input  logic [7:0]        wdata,
  input  logic              wen,
  input  logic              boot_valid,
  input  logic [7:0]        boot_byte,
  output logic              boot_ready,
  output logic              cpu_run,
  output logic              led
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W + 1)'(BOOT_LEN - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_ptr;
  logic              r_cpu_run;
  logic              r_led;
  logic [7:0]        r_mem [DEPTH];

  logic              w_accept;
  logic              w_last;
  logic              w_core_wr;
  logic              w_led_hit;

  assign boot_ready = (r_state == S_LOAD) && reset;
  assign w_accept   = boot_valid && boot_ready;
  assign w_last     = w_accept && (r_ptr == LP_LAST);
  assign w_led_hit  = (daddr == LED_ADDR);
  // Core writes only count in RUN and never on a reset edge.
  assign w_core_wr  = (r_state == S_RUN) && wen && reset;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: LOAD exits on the edge that takes the last boot byte.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_last) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Boot pointer and core-run flag; cpu_run rises together with RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_cpu_run <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 1'b1;
      if (w_last) r_cpu_run <= 1'b1;
    end
  end

  // LED register, written by the core in RUN at LED_ADDR.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_led <= 1'b0;
    end else if (w_core_wr && w_led_hit) begin
      r_led <= wdata[0];
    end
  end

  // Memory array: boot bytes in LOAD, core stores in RUN; never cleared.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_ptr[ADDR_W-1:0]] <= boot_byte;
    end else if (w_core_wr && !w_led_hit) begin
      r_mem[daddr] <= wdata;
    end
  end

  // Asynchronous read ports; the data port sees the LED at LED_ADDR.
  always_comb begin
    inst = r_mem[iaddr];
    data = r_mem[daddr];
    if (w_led_hit) data = {7'b0, r_led};
  end

  assign cpu_run = r_cpu_run;
  assign led     = r_led;

endmodule

// File: doc/nanojeff_mem.md
Name: nanojeff_mem

Overview:
- Synthesizable memory-side responder for the NanoJeff core's bus. The core is the initiator; this block serves its instruction fetches (iaddr→inst) and data loads/stores (daddr/wdata/wen→data).
- Holds the core in reset while a boot image is streamed in over a valid/ready byte interface. Then releases the core.
- Provides one memory-mapped LED register.
- Replaces the behavioural memory used in simulation benches.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W bytes.
- BOOT_LEN, 256, number of bytes loaded before release; legal range 1..2**ADDR_W.
- LED_ADDR, 8'hFF, data address of the LED register.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- iaddr  in  ADDR_W  instruction fetch address from core.
- inst  out  8  instruction byte to core.
- daddr  in  ADDR_W  data address from core.
- data  out  8  read data to core.
- wdata  in  8  write data from core.
- wen  in  1  write enable from core.
- boot_valid  in  1  boot byte present.
- boot_byte  in  8  boot image byte.
- boot_ready  out  1  block accepts boot byte this cycle.
- cpu_run  out  1  high = core may run; drive core reset from its inverse.
- led  out  1  LED register bit.

Behaviour:
- Reset (reset==0 at posedge):
  - state=LOAD, ptr=0, cpu_run=0, led=0.
  - boot_ready is combinational (state==LOAD && reset==1), so it is 0 while reset is low.
  - Memory array contents are not cleared.
- State LOAD:
  - boot_ready=1.
  - On a posedge with boot_valid&&boot_ready: mem[ptr]<=boot_byte and ptr<=ptr+1. ptr is ADDR_W+1 bits wide.
  - When the byte written has ptr==BOOT_LEN-1: state<=RUN and cpu_run<=1 on that same edge.
  - boot_valid low: no change, unlimited stalls allowed.
  - wen is ignored in LOAD; no core writes and no LED updates.
- State RUN:
  - boot_ready=0; boot_valid ignored.
  - The only exit is reset.
- Reads, both states, combinational with zero latency:
  - inst = mem[iaddr].
  - data = {7'b0, led} if daddr==LED_ADDR, else mem[daddr].
  - iaddr==daddr is legal; both ports return the same byte.
- Writes, RUN only, at posedge with wen==1:
  - daddr!=LED_ADDR: mem[daddr]<=wdata.
  - daddr==LED_ADDR: led<=wdata[0]; mem[LED_ADDR] is unchanged.
  - Read-during-write: data/inst show the old value until the edge and the new value after it.
- Boundaries:
  - Reset mid-load: loading restarts at ptr 0; previously loaded bytes stay but will be overwritten.
  - Reset in RUN: cpu_run falls at that edge; led clears; a wen asserted on the reset edge is dropped.
  - BOOT_LEN<2**ADDR_W: addresses ≥BOOT_LEN keep their prior contents.
  - LED_ADDR<BOOT_LEN: the boot byte at LED_ADDR is written to mem, but the data port still reads led.
  - ptr never wraps, because LOAD exits at BOOT_LEN.
- Single clock domain; no multicycle paths. The memory array must be a register array, not a vendor RAM, because reads are asynchronous.

Test Plan:
- Reset low 2 cycles, then stream bytes 0x00..0xFF with boot_valid held high → boot_ready=1 for 256 cycles; cpu_run rises on the edge that accepts byte 0xFF; afterwards inst at iaddr=0x10 reads 0x10 and data at daddr=0x20 reads 0x20.
- Load with boot_valid toggling 1,0,0,1,… → only accepted bytes advance ptr; final memory matches the image; cpu_run rises only after the 256th accepted byte.
- In RUN: wen=1, daddr=0x40, wdata=0xA5 → data reads the old value 0x40 before the edge and 0xA5 after; inst at iaddr=0x40 also reads 0xA5.
- In RUN: wen=1, daddr=0xFF, wdata=0x03 → led=1 and data=0x01. Then wdata=0x02 → led=0. mem[0xFF] stays at its boot value throughout (set LED_ADDR=0xFE to inspect it).
- In LOAD: wen=1, daddr=0x05 → memory and led unchanged. Then assert reset after 100 bytes and restart the stream with 0x80.. → mem[0]=0x80 and cpu_run stays 0 until 256 new bytes are accepted.
- BOOT_LEN=4: load 0x11,0x22,0x33,0x44 → cpu_run=1 after the 4th byte; boot_ready=0 thereafter; extra boot_valid bytes ignored.
